// File: rtl/memory_interface.sv
// memory_interface: byte-addressed big-endian RAM behind a MOV/MOC handshake.
// Requests are latched in IDLE. The FSM then counts WAIT_STATES clocks and
// performs the access on the WAIT-to-DONE edge. It holds MOC until MOV drops.
// The array is organised as four byte lanes indexed by address[1:0]. Lane 0
// holds the lowest address, which is the most significant byte. An aligned
// access therefore always falls inside a single row.
module memory_interface #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              MOV,
  input  logic              R_W,
  input  logic [1:0]        DT,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              MOC,
  output logic              misalign
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned LANES  = 4;
  localparam int unsigned ROW_W  = ADDR_W - 2;
  localparam int unsigned ROWS   = 1 << ROW_W;

  localparam logic [1:0] DT_BYTE = 2'b00;
  localparam logic [1:0] DT_HALF = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                req_rw;
  logic [1:0]          req_dt;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;

  logic [7:0]          mem [LANES][ROWS];

  logic [ROW_W-1:0]    row;
  logic [0:3][7:0]     rd_lane;
  logic [0:3][7:0]     wr_lane;
  logic [0:3]          lane_mask;
  logic [0:3]          lane_we;
  logic [DATA_W-1:0]   rd_data;
  logic                mis;
  logic                commit;

  assign row = req_addr[ADDR_W-1:2];

  // Access completes only when the counter expires with MOV still held.
  assign commit = (state == ST_WAIT) && (cnt == '0) && MOV;

  // Fetch the addressed row from every lane.
  always_comb begin
    rd_lane = '0;
    for (int b = 0; b < int'(LANES); b++) begin
      rd_lane[b] = mem[b][row];
    end
  end

  // Decode size and alignment into lane enables, write lanes and read data.
  // DT = 11 is handled as a word access that always reports misalignment.
  always_comb begin
    lane_mask = '0;
    wr_lane   = '0;
    rd_data   = '0;
    mis       = 1'b0;
    case (req_dt)
      DT_BYTE: begin
        lane_mask[req_addr[1:0]] = 1'b1;
        wr_lane[req_addr[1:0]]   = req_wdata[7:0];
        rd_data                  = {24'b0, rd_lane[req_addr[1:0]]};
      end
      DT_HALF: begin
        lane_mask[{req_addr[1], 1'b0}] = 1'b1;
        lane_mask[{req_addr[1], 1'b1}] = 1'b1;
        wr_lane[{req_addr[1], 1'b0}]   = req_wdata[15:8];
        wr_lane[{req_addr[1], 1'b1}]   = req_wdata[7:0];
        rd_data = {16'b0, rd_lane[{req_addr[1], 1'b0}], rd_lane[{req_addr[1], 1'b1}]};
        mis     = req_addr[0];
      end
      default: begin
        lane_mask = '1;
        wr_lane   = req_wdata;
        rd_data   = rd_lane;
        mis       = (|req_addr[1:0]) || (req_dt == 2'b11);
      end
    endcase
    lane_we = (commit && !req_rw) ? lane_mask : '0;
  end

  // The array has no reset, so stored contents survive clr.
  always_ff @(posedge clk) begin
    for (int b = 0; b < int'(LANES); b++) begin
      if (lane_we[b]) begin
        mem[b][row] <= wr_lane[b];
      end
    end
  end

  // Handshake FSM: latch the request, count wait states, complete, hold MOC.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      req_rw    <= 1'b0;
      req_dt    <= '0;
      req_addr  <= '0;
      req_wdata <= '0;
      data_out  <= '0;
      MOC       <= 1'b0;
      misalign  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (MOV) begin
            req_rw    <= R_W;
            req_dt    <= DT;
            req_addr  <= address;
            req_wdata <= data_in;
            cnt       <= CNT_W'(WAIT_STATES);
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!MOV) begin
            state <= ST_IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state    <= ST_DONE;
            MOC      <= 1'b1;
            misalign <= mis;
            if (req_rw) begin
              data_out <= rd_data;
            end
          end
        end
        ST_DONE: begin
          if (!MOV) begin
            state <= ST_IDLE;
            MOC   <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          MOC   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_interface.sv
// Directed bench for memory_interface: a table of accesses followed by
// handshake, abort, reset and zero-wait-state sequences.
module tb_memory_interface;

  logic        clk;
  logic        clr;
  logic        MOV;
  logic        mov0;
  logic        R_W;
  logic [1:0]  DT;
  logic [7:0]  address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [31:0] dout0;
  logic        MOC;
  logic        moc0;
  logic        misalign;
  logic        mis0;

  int nvec = 0;
  int nerr = 0;

  memory_interface #(.ADDR_W(8), .WAIT_STATES(2)) dut (
    .clk(clk), .clr(clr), .MOV(MOV), .R_W(R_W), .DT(DT), .address(address),
    .data_in(data_in), .data_out(data_out), .MOC(MOC), .misalign(misalign)
  );

  memory_interface #(.ADDR_W(8), .WAIT_STATES(0)) dut0 (
    .clk(clk), .clr(clr), .MOV(mov0), .R_W(R_W), .DT(DT), .address(address),
    .data_in(data_in), .data_out(dout0), .MOC(moc0), .misalign(mis0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [1:0]  dt;
    logic [7:0]  addr;
    logic [31:0] din;
    logic [31:0] exp_dout;
    logic        exp_mis;
  } vec_t;

  vec_t vecs [21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One full handshake on the selected DUT. Inputs are scrambled once the
  // request is latched. MOV is held for 'hold' extra cycles after MOC.
  task automatic access(input bit sel, input logic rw, input logic [1:0] dt,
                        input logic [7:0] addr, input logic [31:0] din, input int hold,
                        output logic [31:0] dout, output logic mis, output int edges,
                        output logic held_ok, output logic drop_ok);
    logic seen;
    @(negedge clk);
    R_W = rw; DT = dt; address = addr; data_in = din;
    if (sel) mov0 = 1'b1; else MOV = 1'b1;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (edges == 1) begin
        R_W = ~rw; DT = ~dt; address = ~addr; data_in = ~din;
      end
      seen = sel ? moc0 : MOC;
    end
    dout = sel ? dout0 : data_out;
    mis  = sel ? mis0 : misalign;
    held_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!(sel ? moc0 : MOC)) held_ok = 1'b0;
    end
    @(negedge clk);
    if (sel) mov0 = 1'b0; else MOV = 1'b0;
    @(posedge clk); #1;
    drop_ok = !(sel ? moc0 : MOC) && ((sel ? dout0 : data_out) === dout);
  endtask

  initial begin
    logic [31:0] d;
    logic        m;
    int          e;
    logic        hok;
    logic        dok;
    logic        seen;

    vecs[0]  = '{1'b0, 2'b10, 8'h04, 32'h11223344, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b1, 2'b10, 8'h04, 32'h0,        32'h11223344, 1'b0};
    vecs[2]  = '{1'b1, 2'b00, 8'h04, 32'h0,        32'h00000011, 1'b0};
    vecs[3]  = '{1'b1, 2'b00, 8'h05, 32'h0,        32'h00000022, 1'b0};
    vecs[4]  = '{1'b1, 2'b00, 8'h06, 32'h0,        32'h00000033, 1'b0};
    vecs[5]  = '{1'b1, 2'b00, 8'h07, 32'h0,        32'h00000044, 1'b0};
    vecs[6]  = '{1'b0, 2'b00, 8'h06, 32'hFFFFFFAB, 32'h00000044, 1'b0};
    vecs[7]  = '{1'b1, 2'b10, 8'h04, 32'h0,        32'h1122AB44, 1'b0};
    vecs[8]  = '{1'b1, 2'b01, 8'h06, 32'h0,        32'h0000AB44, 1'b0};
    vecs[9]  = '{1'b1, 2'b01, 8'h05, 32'h0,        32'h00001122, 1'b1};
    vecs[10] = '{1'b0, 2'b11, 8'h08, 32'hCAFEF00D, 32'h00001122, 1'b1};
    vecs[11] = '{1'b1, 2'b10, 8'h08, 32'h0,        32'hCAFEF00D, 1'b0};
    vecs[12] = '{1'b1, 2'b10, 8'h0A, 32'h0,        32'hCAFEF00D, 1'b1};
    vecs[13] = '{1'b1, 2'b00, 8'h0B, 32'h0,        32'h0000000D, 1'b0};
    vecs[14] = '{1'b0, 2'b01, 8'h0A, 32'h1234BEEF, 32'h0000000D, 1'b0};
    vecs[15] = '{1'b1, 2'b10, 8'h08, 32'h0,        32'hCAFEBEEF, 1'b0};
    vecs[16] = '{1'b1, 2'b01, 8'h08, 32'h0,        32'h0000CAFE, 1'b0};
    vecs[17] = '{1'b0, 2'b10, 8'h10, 32'h55667788, 32'h0000CAFE, 1'b0};
    vecs[18] = '{1'b0, 2'b10, 8'h20, 32'h0BADF00D, 32'h0000CAFE, 1'b0};
    vecs[19] = '{1'b1, 2'b00, 8'h23, 32'h0,        32'h0000000D, 1'b0};
    vecs[20] = '{1'b1, 2'b11, 8'h12, 32'h0,        32'h55667788, 1'b1};

    clr = 1'b1; MOV = 1'b0; mov0 = 1'b0; R_W = 1'b0; DT = 2'b00;
    address = '0; data_in = '0;
    #3 clr = 1'b0;
    #1;
    check("reset_moc", 32'(MOC), 32'(0));
    check("reset_dout", data_out, 32'h0);
    check("reset_mis", 32'(misalign), 32'(0));
    @(negedge clk);
    clr = 1'b1;

    // Table of accesses on the two-wait-state DUT.
    for (int i = 0; i < 21; i++) begin
      access(1'b0, vecs[i].rw, vecs[i].dt, vecs[i].addr, vecs[i].din, 0, d, m, e, hok, dok);
      check($sformatf("vec%0d_latency", i), 32'(e), 32'(4));
      check($sformatf("vec%0d_dout", i), d, vecs[i].exp_dout);
      check($sformatf("vec%0d_misalign", i), 32'(m), 32'(vecs[i].exp_mis));
      check($sformatf("vec%0d_moc_drop", i), 32'(dok), 32'(1));
    end

    // MOV held five cycles past MOC.
    access(1'b0, 1'b1, 2'b10, 8'h04, 32'h0, 5, d, m, e, hok, dok);
    check("hold_dout", d, 32'h1122AB44);
    check("hold_moc_stays", 32'(hok), 32'(1));
    check("hold_moc_drop", 32'(dok), 32'(1));

    // Write aborted during WAIT never lands.
    @(negedge clk);
    R_W = 1'b0; DT = 2'b10; address = 8'h10; data_in = 32'hDEADBEEF; MOV = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    MOV = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      seen = seen | MOC;
    end
    check("abort_no_moc", 32'(seen), 32'(0));
    access(1'b0, 1'b1, 2'b10, 8'h10, 32'h0, 0, d, m, e, hok, dok);
    check("abort_mem_kept", d, 32'h55667788);

    // Asynchronous clear between edges, then a quiet idle period.
    @(negedge clk);
    #2 clr = 1'b0;
    #1;
    check("async_clr_dout", data_out, 32'h0);
    check("async_clr_moc", 32'(MOC), 32'(0));
    @(negedge clk);
    clr = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      seen = seen | MOC;
    end
    check("idle_no_moc", 32'(seen), 32'(0));

    // Clear during WAIT of a write drops the write.
    @(negedge clk);
    R_W = 1'b0; DT = 2'b10; address = 8'h20; data_in = 32'h12345678; MOV = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 clr = 1'b0;
    #1;
    check("midwrite_clr_moc", 32'(MOC), 32'(0));
    MOV = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    access(1'b0, 1'b1, 2'b10, 8'h20, 32'h0, 0, d, m, e, hok, dok);
    check("midwrite_mem_kept", d, 32'h0BADF00D);

    // Zero-wait-state instance completes on the edge after sampling.
    access(1'b1, 1'b0, 2'b10, 8'h30, 32'hA1B2C3D4, 0, d, m, e, hok, dok);
    check("ws0_write_latency", 32'(e), 32'(2));
    check("ws0_write_drop", 32'(dok), 32'(1));
    access(1'b1, 1'b1, 2'b00, 8'h31, 32'h0, 0, d, m, e, hok, dok);
    check("ws0_read_latency", 32'(e), 32'(2));
    check("ws0_read_dout", d, 32'h000000B2);
    access(1'b1, 1'b1, 2'b01, 8'h33, 32'h0, 0, d, m, e, hok, dok);
    check("ws0_half_dout", d, 32'h0000C3D4);
    check("ws0_half_mis", 32'(m), 32'(1));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/memory_interface.md
Name: memory_interface

Overview:
- Byte-addressed, big-endian data/instruction RAM with a MOV/MOC handshake and programmable wait states.
- Sits directly downstream of the ControlUnit. It consumes MOV, R_W and DT, plus the address from MAR and write data from MDR.
- It returns MOC and the read data that MDR and IR load.

Parameters:
- ADDR_W, 8, address width; array depth is 2**ADDR_W bytes.
- WAIT_STATES, 2, extra clocks between accepting a request and asserting MOC (legal range 0..15).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  reset, asynchronous, active-low; the only reset.
- MOV  input  1  memory operation valid, from ControlUnit; held high until MOC is seen.
- R_W  input  1  1 = read, 0 = write; sampled with MOV.
- DT  input  2  data type: 00 byte, 01 halfword, 10 word, 11 reserved.
- address  input  ADDR_W  byte address, from MAR.
- data_in  input  32  write data, from MDR; right-justified for byte and halfword.
- data_out  output  32  read data, zero-extended for byte and halfword.
- MOC  output  1  memory operation complete.
- misalign  output  1  flags a misaligned or reserved-DT access; valid while MOC = 1.

Behaviour:
- Reset (clr = 0, async):
  - State = IDLE; MOC = 0, data_out = 0, misalign = 0, wait counter = 0.
  - The memory array is not cleared; its contents survive reset.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - On a rising edge with MOV = 1, latch address, R_W, DT and data_in.
  - Load the counter with WAIT_STATES and go to WAIT. MOC stays 0.
- WAIT:
  - If counter != 0: decrement it and stay in WAIT.
  - If counter == 0: perform the access on this edge and go to DONE with MOC = 1.
  - MOV dropping during WAIT aborts: return to IDLE with no access performed. A write that is not yet committed never happens.
- DONE:
  - MOC = 1, data_out holds the read result, misalign is valid.
  - Stay in DONE while MOV = 1.
  - On the first edge with MOV = 0: go to IDLE, MOC = 0, data_out keeps its last value.
  - A new request needs at least one IDLE cycle.
- Latency: MOV sampled high at edge k gives MOC = 1 after edge k+1+WAIT_STATES. With default parameters that is edge k+3.
- Alignment: the effective address clears the low bits, bit0 for halfword and bits[1:0] for word. misalign = 1 when any cleared bit was set.
- DT = 11 is treated as a word access with misalign = 1.
- Read (big-endian, A = effective address):
  - byte: data_out = {24'b0, mem[A]}.
  - halfword: data_out = {16'b0, mem[A], mem[A+1]}.
  - word: data_out = {mem[A], mem[A+1], mem[A+2], mem[A+3]}.
- Write:
  - byte: mem[A] = data_in[7:0].
  - halfword: mem[A] = data_in[15:8], mem[A+1] = data_in[7:0].
  - word: mem[A..A+3] = data_in[31:24], [23:16], [15:8], [7:0].
  - The write commits exactly once, on the WAIT-to-DONE edge.
  - data_out is unchanged by writes.
- Address handling: aligned accesses never straddle the end of the array, so no wrap logic is required.
- Inputs changing after latch have no effect until the next IDLE acceptance.
- Reset mid-operation: immediate return to IDLE.
  - An access before commit is lost.
  - An access already committed stays in the array.
- A $readmemh preload hook for simulation is permitted; synthesis ignores it.

Test Plan:
- Reset/idle: clr = 0 pulse between edges, MOV = 0 -> MOC = 0, data_out = 0 immediately (async); no MOC over 10 cycles.
- Word write/read: write word 0x11223344 at address 0x04, then word read at 0x04 -> data_out = 0x11223344. Byte reads of 0x04..0x07 -> 0x11, 0x22, 0x33, 0x44. MOC rises exactly 3 edges after MOV is sampled; misalign = 0.
- Halfword/byte write: write byte 0xAB at 0x06 (data_in = 0xFFFFFFAB) over the previous word -> word read at 0x04 = 0x1122AB44. Halfword read at 0x06 -> 0x0000AB44.
- Misalign: halfword read at 0x05 -> reads 0x04/0x05 = 0x00001122, misalign = 1. Word access with DT = 11 at 0x08 -> misalign = 1.
- Handshake hold/abort:
  - MOV held 5 cycles after MOC -> MOC stays 1 throughout; drops one edge after MOV falls.
  - Write 0xDEADBEEF to 0x10 with MOV dropped in WAIT -> no MOC; a later read of 0x10 returns the old value.
- Reset mid-write: clr asserted during WAIT of a write to 0x20 -> MOC = 0, word read of 0x20 unchanged. WAIT_STATES = 0 build -> MOC on the edge after MOV is sampled.
